// File: rtl/conv_pkg.sv
// Shared constants and window indexing for the convolution data mover.
// Window elements are packed row-major, element (r,c) at offset (3*r+c)*width.
package conv_pkg;

    localparam int KSIZE = 3;
    localparam int WIN_N = KSIZE * KSIZE;

    function automatic int win_idx(input int r, input int c, input int dw);
        return (KSIZE * r + c) * dw;
    endfunction

endpackage

// File: rtl/conv_window_reader_line_delay.sv
// Enable-gated shift register delaying a pixel stream by DEPTH accepted pixels.
// The output is the oldest entry; it only advances when en is high.
module line_delay #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv_window_reader.sv
// Turns a raster pixel stream into 3x3 windows (stride 1, no padding) for im2col.
// Handshake: a beat transfers on a rising edge where valid && ready; once valid, data holds until ready.
module conv_window_reader
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 14,
    parameter int IMG_H      = 14
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_WIDTH-1:0]       s_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [WIN_N*DATA_WIDTH-1:0] m_window,
    output logic                        m_last,
    output logic                        frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0]               col;
    logic [RW-1:0]               row;
    logic                        acc;
    logic                        emit;
    logic                        col_end;
    logic                        row_end;
    logic [DATA_WIDTH-1:0]       ld0_out;
    logic [DATA_WIDTH-1:0]       ld1_out;
    logic [DATA_WIDTH-1:0]       new_col [KSIZE];
    logic [WIN_N*DATA_WIDTH-1:0] win_q;
    logic [WIN_N*DATA_WIDTH-1:0] win_d;

    assign s_ready    = !m_valid || m_ready;
    // A pixel offered alongside clr is dropped and leaves no trace.
    assign acc        = s_valid && s_ready && !clr;
    assign col_end    = (col == CW'(IMG_W - 1));
    assign row_end    = (row == RW'(IMG_H - 1));
    assign emit       = acc && (row >= RW'(2)) && (col >= CW'(2));
    assign frame_done = m_valid && m_ready && m_last;

    line_delay #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W)) u_ld0 (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (acc),
        .din  (s_data),
        .dout (ld0_out)
    );

    line_delay #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W)) u_ld1 (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (acc),
        .din  (ld0_out),
        .dout (ld1_out)
    );

    assign new_col[0] = ld1_out;
    assign new_col[1] = ld0_out;
    assign new_col[2] = s_data;

    always_comb begin
        win_d = win_q;
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE - 1; c++) begin
                win_d[win_idx(r, c, DATA_WIDTH) +: DATA_WIDTH] =
                    win_q[win_idx(r, c + 1, DATA_WIDTH) +: DATA_WIDTH];
            end
            win_d[win_idx(r, KSIZE - 1, DATA_WIDTH) +: DATA_WIDTH] = new_col[r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col   <= '0;
            row   <= '0;
            win_q <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (acc) begin
            win_q <= win_d;
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Output register: a new emit may replace a window in the same cycle it is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            m_window <= '0;
        end else if (clr) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else if (emit) begin
            m_valid  <= 1'b1;
            m_window <= win_d;
            m_last   <= row_end && col_end;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_reader.sv
// Directed bench for conv_window_reader: 14x14 frames, stalls, back-to-back frames, clr and reset.
// Expected windows come from a coordinate model of the frame plus hand-written first/last windows.
module tb_conv_window_reader;

  localparam int DW = 8;
  localparam int IW = 14;
  localparam int IH = 14;
  localparam int WW = 9 * DW;
  localparam int NPIX = IW * IH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [WW-1:0] m_window;
  logic          m_last;
  logic          frame_done;

  logic [WW:0]   exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            win_cnt = 0;
  int            fd_cnt = 0;
  int            rdy_mode = 0;
  logic          mready_man = 1'b1;
  logic          stall_prev = 1'b0;
  logic [WW:0]   hold_val = '0;
  logic [WW-1:0] first_win;
  logic [WW-1:0] last_win;
  int            w0;
  int            f0;

  conv_window_reader #(.DATA_WIDTH(DW), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_window  (m_window),
    .m_last    (m_last),
    .frame_done(frame_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix_val(input int mode, input int p);
    int v;
    v = (mode == 0) ? p : 255 - p;
    return v[DW-1:0];
  endfunction

  function automatic logic [WW-1:0] model_win(input int mode, input int p);
    logic [WW-1:0] w;
    int r;
    int c;
    r = p / IW;
    c = p % IW;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(3*i+j)*DW +: DW] = pix_val(mode, (r - 2 + i) * IW + (c - 2 + j));
    return w;
  endfunction

  function automatic logic [WW-1:0] pack9(input int e[9]);
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[k*DW +: DW] = DW'(e[k]);
    return w;
  endfunction

  // m_ready driver: 0 = always ready, 1 = random 50%, 2 = follow mready_man
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) m_ready = 1'($urandom_range(0, 1));
      else if (rdy_mode == 2) m_ready = mready_man;
      else m_ready = 1'b1;
    end
  end

  // scoreboard / monitor
  always @(negedge clk) begin
    logic [WW:0] e;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) check("stall_hold", 80'({m_last, m_window}), 80'(hold_val));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_window", 80'(1), 80'(0));
        end else begin
          e = exp_q.pop_front();
          check("window", 80'({m_last, m_window}), 80'(e));
          check("frame_done", 80'(frame_done), 80'(e[WW]));
        end
        win_cnt++;
      end
      if (frame_done) fd_cnt++;
      stall_prev = m_valid && !m_ready;
      hold_val = {m_last, m_window};
    end
  end

  // driver tasks
  task automatic send_pixel(input logic [DW-1:0] d);
    int n;
    s_valid = 1'b1;
    s_data = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n > 1000) begin
        check("accept_timeout", 80'(0), 80'(1));
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_range(input int mode, input int lo, input int hi, input bit gaps, input bit probe);
    for (int p = lo; p <= hi; p++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      if ((p / IW) >= 2 && (p % IW) >= 2)
        exp_q.push_back({1'(p == NPIX - 1), model_win(mode, p)});
      send_pixel(pix_val(mode, p));
      if (probe && p == 29) check("no_early_window", 80'(m_valid), 80'(0));
      if (probe && p == 30) begin
        check("first_valid", 80'(m_valid), 80'(1));
        check("first_window", 80'(m_window), 80'(first_win));
      end
      if (probe && p == NPIX - 1) begin
        check("last_window", 80'(m_window), 80'(last_win));
        check("last_flag", 80'(m_last), 80'(1));
        check("last_done", 80'(frame_done), 80'(1));
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 80'(exp_q.size()), 80'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int fl[9];
    int ll[9];
    fl = '{0, 1, 2, 14, 15, 16, 28, 29, 30};
    ll = '{165, 166, 167, 179, 180, 181, 193, 194, 195};
    first_win = pack9(fl);
    last_win = pack9(ll);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 80'(m_valid), 80'(0));
    check("rst_m_last", 80'(m_last), 80'(0));
    check("rst_m_window", 80'(m_window), 80'(0));
    check("rst_frame_done", 80'(frame_done), 80'(0));
    check("rst_s_ready", 80'(s_ready), 80'(1));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ramp frame, always ready
    w0 = win_cnt; f0 = fd_cnt;
    send_range(0, 0, NPIX - 1, 1'b0, 1'b1);
    drain();
    check("ramp_count", 80'(win_cnt - w0), 80'(144));
    check("ramp_done", 80'(fd_cnt - f0), 80'(1));

    // random ready and input gaps
    w0 = win_cnt; f0 = fd_cnt;
    rdy_mode = 1;
    send_range(0, 0, NPIX - 1, 1'b1, 1'b0);
    drain();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rand_count", 80'(win_cnt - w0), 80'(144));
    check("rand_done", 80'(fd_cnt - f0), 80'(1));

    // two frames back-to-back
    w0 = win_cnt; f0 = fd_cnt;
    send_range(0, 0, NPIX - 1, 1'b0, 1'b1);
    send_range(0, 0, NPIX - 1, 1'b0, 1'b1);
    drain();
    check("b2b_count", 80'(win_cnt - w0), 80'(288));
    check("b2b_done", 80'(fd_cnt - f0), 80'(2));

    // stall with pending window, then release with s_valid held
    rdy_mode = 2;
    mready_man = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_range(0, 0, 30, 1'b0, 1'b0);
    s_valid = 1'b1;
    s_data = pix_val(0, 31);
    repeat (3) begin
      @(negedge clk);
      check("stall_s_ready", 80'(s_ready), 80'(0));
      check("stall_m_valid", 80'(m_valid), 80'(1));
    end
    mready_man = 1'b1;
    exp_q.push_back({1'b0, model_win(0, 31)});
    send_pixel(pix_val(0, 31));
    check("reload_valid", 80'(m_valid), 80'(1));
    check("reload_pix", 80'(m_window[8*DW +: DW]), 80'(31));
    rdy_mode = 0;
    send_range(0, 32, NPIX - 1, 1'b0, 1'b0);
    drain();

    // clr mid-frame at pixel 100
    send_range(0, 0, 99, 1'b0, 1'b0);
    clr = 1'b1;
    s_valid = 1'b1;
    s_data = pix_val(0, 100);
    @(posedge clk);
    #1;
    clr = 1'b0;
    s_valid = 1'b0;
    check("clr_m_valid", 80'(m_valid), 80'(0));
    check("clr_m_last", 80'(m_last), 80'(0));
    drain();
    w0 = win_cnt; f0 = fd_cnt;
    send_range(0, 0, NPIX - 1, 1'b0, 1'b1);
    drain();
    check("clr_count", 80'(win_cnt - w0), 80'(144));
    check("clr_done", 80'(fd_cnt - f0), 80'(1));

    // asynchronous reset mid-frame with a window pending
    send_range(1, 0, 45, 1'b0, 1'b0);
    check("pre_rst_valid", 80'(m_valid), 80'(1));
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("arst_m_valid", 80'(m_valid), 80'(0));
    check("arst_m_window", 80'(m_window), 80'(0));
    check("arst_m_last", 80'(m_last), 80'(0));
    check("arst_s_ready", 80'(s_ready), 80'(1));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    w0 = win_cnt; f0 = fd_cnt;
    send_range(0, 0, NPIX - 1, 1'b0, 1'b1);
    drain();
    check("arst_count", 80'(win_cnt - w0), 80'(144));
    check("arst_done", 80'(fd_cnt - f0), 80'(1));

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
